if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Fetch end of the load-use stall handshake. Consumes pc_write/if_id_write from the
//  hazard unit and owns the PC register, the instruction-memory request, and the IF/ID
//  pipeline register. Inserts bubbles on memory wait, flushes on branch/jump redirect,
//  and buffers one fetched word while ID is stalled.
// PARAMETERS
//  PC_RESET  32'h0000_0000  PC value loaded on reset
//  NOP_INSTR 32'h0000_0000  word written into IF/ID on bubble/flush (sll $0,$0,0)
//  CNT_W     16             width of the saturating stall counter
// PORTS
//  clock            in  1   single clock, rising edge
//  reset            in  1   asynchronous, active-low reset
//  pc_write         in  1   1 = PC may advance (hazard unit)
//  if_id_write      in  1   1 = IF/ID may load (hazard unit)
//  branch_taken     in  1   redirect to branch_target (resolved in ID)
//  branch_target    in  32  branch destination
//  jump             in  1   redirect to jump_target
//  jump_target      in  32  jump destination
//  imem_req         out 1   fetch request; imem_addr valid while high
//  imem_addr        out 32  fetch address (= pc)
//  imem_ready       in  1   fetch completes this cycle (sampled only when imem_req=1)
//  imem_rdata       in  32  instruction word, valid with imem_ready
//  pc               out 32  current PC
//  if_id_instruction out 32 IF/ID instruction
//  if_id_pc_plus4   out 32  IF/ID PC+4 of that instruction
//  if_id_valid      out 1   1 = IF/ID holds a real instruction
//  fetch_stall      out 1   imem_req & ~imem_ready
//  stall_count      out CNT_W cycles IF/ID held a valid instr under if_id_write=0
// BEHAVIOUR
//  Reset (reset=0, async): pc=PC_RESET, state=IDLE, imem_req=0, if_id_instruction=NOP_INSTR,
//   if_id_pc_plus4=0, if_id_valid=0, hold buffer empty, stall_count=0.
//  States: IDLE -> FETCH unconditionally on first clock after reset release.
//   FETCH: imem_req=1, imem_addr=pc held stable until imem_ready or redirect.
//   HOLD : imem_req=0; one fetched word + its pc+4 in hold buffer.
//  advance = pc_write & if_id_write; pc_write/if_id_write disagreeing is treated as stall.
//  redirect = branch_taken | jump; target priority: branch_target > jump_target.
//  Per clock, priority order:
//   1 redirect: pc<=target, IF/ID<=NOP/valid=0, hold buffer dropped, in-flight fetch
//     discarded (ready this cycle ignored), state<=FETCH. Applies even if advance=0.
//   2 FETCH & ready & advance: IF/ID<={rdata,pc+4,1}; pc<=pc+4; stay FETCH (back-to-back).
//   3 FETCH & ready & ~advance: buffer<={rdata,pc+4}; pc unchanged; state<=HOLD; IF/ID holds.
//   4 FETCH & ~ready: advance -> IF/ID<=NOP/valid=0 (bubble); else IF/ID holds.
//   5 HOLD & advance: IF/ID<=buffer, valid=1; pc<=pc+4; state<=FETCH.
//   6 HOLD & ~advance: everything holds.
//  Latency: imem_ready in cycle N -> if_id_* valid in N+1 (no stall).
//  Arithmetic: pc+4 mod 2^32; 32'hFFFF_FFFC wraps to 0, no flag.
//  stall_count: +1 each cycle ~if_id_write & if_id_valid; saturates at all-ones.
//  No instruction lost or duplicated across any stall/redirect sequence.
// STRUCTURE
//  Shared header mips_defs.vh: NOP_INSTR, state encodings (IDLE/FETCH/HOLD), PC_RESET.
//  One sub-module: pc_next_mux (combinational target select: branch > jump > pc+4).
//  PC, IF/ID, hold buffer and counter stay in the top module.
// TESTING
//  1 Reset mid-run: assert reset with valid IF/ID -> all outputs at reset values same
//    cycle; after release imem_req=0 one cycle, then 1 with imem_addr=0.
//  2 Stream, ready always 1, advance=1 -> if_id_pc_plus4 = 4,8,12,...; one instr/clock.
//  3 Load-use stall: word 0x8C0A0004 fetched with if_id_write=0 for 3 cycles -> HOLD,
//    imem_req=0, stall_count +3, then on release IF/ID=0x8C0A0004 exactly once.
//  4 Memory wait: imem_ready low 2 cycles at pc=0x10 -> fetch_stall=1, two bubbles
//    (valid=0), imem_addr stable 0x10, then instr at pc_plus4=0x14.
//  5 Redirect: branch_taken & jump same cycle, targets 0x40/0x80, while in HOLD ->
//    pc=0x40, IF/ID=NOP valid=0, buffer dropped; next fetch addr 0x40.
//  6 Wrap/saturate: pc=32'hFFFF_FFFC fetch -> pc=0; force 2^CNT_W stall cycles ->
//    stall_count stays all-ones.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset PC, bubble word, FSM states and IF/ID payload.
package if_fetch_stage_pkg;

   localparam logic [31:0] PC_RESET_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
   localparam int          CNT_W_DEF     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;

   // One fetched instruction together with the PC+4 that travels with it.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
   } fetch_word_t;

   // Sequential PC step; wraps modulo 2^32 with no flag.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_stage_pc_next_mux.sv
// Next-PC select: branch target wins over jump target, otherwise sequential PC+4.
module if_fetch_stage_pc_next_mux (
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic [31:0] pc_plus4_i,
   output logic [31:0] pc_next_o
);

   // Fixed-priority target selection.
   always_comb begin
      pc_next_o = pc_plus4_i;
      if (branch_taken_i)  pc_next_o = branch_target_i;
      else if (jump_i)     pc_next_o = jump_target_i;
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns PC, imem request, IF/ID register and a one-word
// hold buffer that catches a completed fetch while ID is stalled.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
   parameter int          CNT_W     = CNT_W_DEF
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             pc_write_i,
   input  logic             if_id_write_i,
   input  logic             branch_taken_i,
   input  logic [31:0]      branch_target_i,
   input  logic             jump_i,
   input  logic [31:0]      jump_target_i,
   output logic             imem_req_o,
   output logic [31:0]      imem_addr_o,
   input  logic             imem_ready_i,
   input  logic [31:0]      imem_rdata_i,
   output logic [31:0]      pc_o,
   output logic [31:0]      if_id_instruction_o,
   output logic [31:0]      if_id_pc_plus4_o,
   output logic             if_id_valid_o,
   output logic             fetch_stall_o,
   output logic [CNT_W-1:0] stall_count_o
);

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   fetch_word_t      ifid_q, ifid_d;
   logic             ifid_vld_q, ifid_vld_d;
   fetch_word_t      hold_q, hold_d;
   logic [CNT_W-1:0] stall_cnt_q;

   logic        advance, redirect, fetch_done;
   logic [31:0] pc_plus4, pc_next;

   // A half-granted stall (only one of the two writes) is treated as a full stall.
   assign advance    = pc_write_i & if_id_write_i;
   assign redirect   = branch_taken_i | jump_i;
   assign pc_plus4   = pc_inc(pc_q);
   assign fetch_done = (state_q == ST_FETCH) & imem_ready_i;

   if_fetch_stage_pc_next_mux u_pc_next_mux (
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .jump_i          (jump_i),
      .jump_target_i   (jump_target_i),
      .pc_plus4_i      (pc_plus4),
      .pc_next_o       (pc_next)
   );

   // Next-state logic: redirect overrides everything, including a fetch completing now.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ifid_d     = ifid_q;
      ifid_vld_d = ifid_vld_q;
      hold_d     = hold_q;
      if (redirect) begin
         pc_d       = pc_next;
         ifid_d     = '{instr: NOP_INSTR, pc_plus4: 32'h0};
         ifid_vld_d = 1'b0;
         state_d    = ST_FETCH;
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
               if (fetch_done && advance) begin
                  ifid_d     = '{instr: imem_rdata_i, pc_plus4: pc_plus4};
                  ifid_vld_d = 1'b1;
                  pc_d       = pc_next;
               end else if (fetch_done) begin
                  hold_d  = '{instr: imem_rdata_i, pc_plus4: pc_plus4};
                  state_d = ST_HOLD;
               end else if (advance) begin
                  ifid_d     = '{instr: NOP_INSTR, pc_plus4: 32'h0};
                  ifid_vld_d = 1'b0;
               end
            end
            ST_HOLD: begin
               // PC still points at the buffered word, so pc+4 is its successor.
               if (advance) begin
                  ifid_d     = hold_q;
                  ifid_vld_d = 1'b1;
                  pc_d       = pc_next;
                  state_d    = ST_FETCH;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, PC, IF/ID and hold buffer registers.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= ST_IDLE;
         pc_q       <= PC_RESET;
         ifid_q     <= '{instr: NOP_INSTR, pc_plus4: 32'h0};
         ifid_vld_q <= 1'b0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ifid_q     <= ifid_d;
         ifid_vld_q <= ifid_vld_d;
         hold_q     <= hold_d;
      end
   end

   // Saturating count of cycles a valid IF/ID entry was held by the hazard unit.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni)
         stall_cnt_q <= '0;
      else if (!if_id_write_i && ifid_vld_q && (stall_cnt_q != '1))
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
   end

   assign imem_req_o          = (state_q == ST_FETCH);
   assign imem_addr_o         = pc_q;
   assign pc_o                = pc_q;
   assign if_id_instruction_o = ifid_q.instr;
   assign if_id_pc_plus4_o    = ifid_q.pc_plus4;
   assign if_id_valid_o       = ifid_vld_q;
   assign fetch_stall_o       = imem_req_o & ~imem_ready_i;
   assign stall_count_o       = stall_cnt_q;

endmodule
